// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit holding the HI/LO registers.
// mult/multu run shift-add over N cycles; div/divu run restoring
// shift-subtract over N cycles; a final cycle applies sign correction.
// Optional feature macro: MDU_DIV_EN builds the divider and enables
// div/divu. Without it, starts with op[1]=1 are ignored.
module mul_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] src1,
  input  logic [N-1:0] src2,
  input  logic         wr_hi,
  input  logic         wr_lo,
  input  logic [N-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [N-1:0]     hi_q, lo_q;
  logic             accept;

  // Datapath registers: no reset, they are always loaded on an accepted start.
  logic [2*N-1:0]   acc_q;
  logic [N-1:0]     opb_q;
  logic             neg_lo_q;
  logic [N:0]       mul_sum;
  logic [2*N-1:0]   mul_next;
  logic [N-1:0]     res_hi, res_lo;

`ifdef MDU_DIV_EN
  logic [N-1:0]     rem_q;
  logic             is_div_q, neg_hi_q, dz_q;
  logic [N:0]       rem_sh;
  logic             div_ge;
  logic [N-1:0]     rem_next;
`endif

  // Magnitude of an operand; only signed ops strip the sign.
  function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic sgn_op);
    logic [N-1:0] r;
    r = v;
    if (sgn_op && v[N-1]) r = ~v + 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] neg_n(input logic [N-1:0] v, input logic neg);
    logic [N-1:0] r;
    r = neg ? (~v + 1'b1) : v;
    return r;
  endfunction

  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v, input logic neg);
    logic [2*N-1:0] r;
    r = neg ? (~v + 1'b1) : v;
    return r;
  endfunction

`ifdef MDU_DIV_EN
  assign accept = start && (state_q == IDLE);
`else
  assign accept = start && (state_q == IDLE) && !op[1];
`endif

  // Next-state logic for the IDLE -> RUN -> FIX sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CW'(N - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration step for each algorithm plus the sign-corrected result.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*N-1:N]} + ({1'b0, opb_q} & {(N+1){acc_q[0]}});
    mul_next = {mul_sum, acc_q[N-1:1]};
    {res_hi, res_lo} = neg_2n(acc_q, neg_lo_q);
`ifdef MDU_DIV_EN
    rem_sh   = {rem_q, acc_q[N-1]};
    div_ge   = (rem_sh >= {1'b0, opb_q});
    rem_next = div_ge ? N'(rem_sh - {1'b0, opb_q}) : N'(rem_sh);
    if (is_div_q) begin
      res_lo = dz_q ? '1 : neg_n(acc_q[N-1:0], neg_lo_q);
      res_hi = neg_n(rem_q, neg_hi_q);
    end
`endif
  end

  // Control state, handshake outputs and the architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == FIX);
      if (state_q == RUN) cnt_q <= cnt_q + 1'b1;
      else                cnt_q <= '0;
      if (state_q == FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (!busy_q) begin
        if (wr_hi) hi_q <= wr_data;
        if (wr_lo) lo_q <= wr_data;
      end
    end
  end

  // Operand latch on start, then one multiply or divide step per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      neg_lo_q <= op[0] & (src1[N-1] ^ src2[N-1]);
`ifdef MDU_DIV_EN
      is_div_q <= op[1];
      neg_hi_q <= op[0] & src1[N-1];
      dz_q     <= (src2 == '0);
      rem_q    <= '0;
`endif
      if (op[1]) begin
        acc_q <= {{N{1'b0}}, mag(src1, op[0])};
        opb_q <= mag(src2, op[0]);
      end else begin
        acc_q <= {{N{1'b0}}, mag(src2, op[0])};
        opb_q <= mag(src1, op[0]);
      end
    end else if (state_q == RUN) begin
`ifdef MDU_DIV_EN
      if (is_div_q) begin
        rem_q          <= rem_next;
        acc_q[N-1:0]   <= {acc_q[N-2:0], div_ge};
      end else begin
        acc_q <= mul_next;
      end
`else
      acc_q <= mul_next;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed vectors plus randomized operations
// compared against an arithmetic reference model. Honours MDU_DIV_EN.
module tb_mul_div_unit;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [N-1:0]  src1 = '0, src2 = '0, wr_data = '0;
  logic          wr_hi = 1'b0, wr_lo = 1'b0;
  logic          busy, done;
  logic [N-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src1(src1), .src2(src2), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = o[0] ? longint'($signed(a)) : longint'({32'b0, a});
    sb = o[0] ? longint'($signed(b)) : longint'({32'b0, b});
    if (!o[1]) begin
      p = sa * sb;
      return 64'(p);
    end
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, scramble operands after the start edge, wait for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int lat, output bit held, output logic bsy0);
    logic [31:0] ph, pl;
    @(negedge clk);
    op = o; src1 = a; src2 = b; start = 1'b1;
    ph = hi; pl = lo;
    @(posedge clk); #1;
    start = 1'b0; src1 = $urandom; src2 = $urandom; op = 2'($urandom);
    bsy0 = busy; lat = -1; held = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (hi !== ph || lo !== pl || busy !== 1'b1) held = 1'b0;
    end
    rh = hi; rl = lo;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] vh, vl;
    vh = $urandom; vl = $urandom;
    @(negedge clk); wr_hi = 1'b1; wr_data = vh;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wr_data = vl;
    @(negedge clk); wr_lo = 1'b0;
    checks++; if (hi !== vh) begin errors++; $display("FAIL mthi got %h want %h", hi, vh); end
    checks++; if (lo !== vl) begin errors++; $display("FAIL mtlo got %h want %h", lo, vl); end
  endtask

  task automatic test_multu_max();
    logic [31:0] rh, rl; int lat; bit held; logic b0;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, lat, held, b0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL multu_max_busy got %0b want 1", b0); end
    checks++; if (lat != N + 1) begin errors++; $display("FAIL multu_max_latency got %0d want %0d", lat, N + 1); end
    checks++; if (!held) begin errors++; $display("FAIL multu_max_hold got changed want stable"); end
    checks++; if (rh !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_max_hi got %h want fffffffe", rh); end
    checks++; if (rl !== 32'h00000001) begin errors++; $display("FAIL multu_max_lo got %h want 00000001", rl); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_max_busy_end got %0b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %0b want 0", done); end
  endtask

  task automatic test_mult_small();
    logic [31:0] rh, rl; int lat; bit held; logic b0;
    run_op(2'b01, 32'hFFFFFFFD, 32'd5, rh, rl, lat, held, b0);
    checks++; if (rh !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi got %h want ffffffff", rh); end
    checks++; if (rl !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_neg_lo got %h want fffffff1", rl); end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div_cases();
    logic [31:0] rh, rl; int lat; bit held; logic b0;
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, rh, rl, lat, held, b0);
    checks++; if (rl !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", rl); end
    checks++; if (rh !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", rh); end
    checks++; if (lat != N + 1) begin errors++; $display("FAIL div_latency got %0d want %0d", lat, N + 1); end
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, rh, rl, lat, held, b0);
    checks++; if (rl !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", rl); end
    checks++; if (rh !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", rh); end
    run_op(2'b10, 32'd100, 32'd0, rh, rl, lat, held, b0);
    checks++; if (rl !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_zero_lo got %h want ffffffff", rl); end
    checks++; if (rh !== 32'd100) begin errors++; $display("FAIL divu_zero_hi got %h want 64", rh); end
    run_op(2'b11, 32'hFFFFFFF9, 32'd0, rh, rl, lat, held, b0);
    checks++; if (rl !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_zero_lo got %h want ffffffff", rl); end
    checks++; if (rh !== 32'hFFFFFFF9) begin errors++; $display("FAIL div_zero_hi got %h want fffffff9", rh); end
  endtask
`else
  task automatic test_no_div();
    bit seen;
    @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h00001234;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b10; src1 = 32'd100; src2 = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin errors++; $display("FAIL nodiv_ignored got busy/done activity want none"); end
    checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL nodiv_hi got %h want 00001234", hi); end
    checks++; if (lo !== 32'h00001234) begin errors++; $display("FAIL nodiv_lo got %h want 00001234", lo); end
  endtask
`endif

  task automatic test_ignore_busy();
    int lat;
    @(negedge clk); op = 2'b00; src1 = 32'd2; src2 = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; start = 1'b1; op = 2'b00; src1 = 32'd7; src2 = 32'd9; wr_lo = 1'b1; wr_data = 32'h55;
    @(posedge clk); #1; start = 1'b0; wr_lo = 1'b0;
    checks++; if (lo === 32'h55) begin errors++; $display("FAIL busy_wr_lo got %h want not 00000055", lo); end
    lat = -1;
    for (int k = 11; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++; if (lat != N + 1) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, N + 1); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ignore_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL ignore_lo got %h want 6", lo); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hA5A5A5A5;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; src1 = 32'd2; src2 = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midreset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midreset_lo got %h want 0", lo); end
    @(negedge clk); reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rh, rl, a, b; logic [1:0] o; logic [63:0] exp;
    int lat; bit held; logic b0;
    for (int i = 0; i < 24; i++) begin
`ifdef MDU_DIV_EN
      o = 2'($urandom);
`else
      o = {1'b0, 1'($urandom)};
`endif
      a = pick(); b = pick();
      exp = model(o, a, b);
      run_op(o, a, b, rh, rl, lat, held, b0);
      checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d] got %0b want 1", i, b0); end
      checks++; if (lat != N + 1) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, N + 1); end
      checks++; if (!held) begin errors++; $display("FAIL b2b_hold[%0d] got changed want stable", i); end
      checks++;
      if ({rh, rl} !== exp) begin
        errors++;
        $display("FAIL b2b_result[%0d] op=%0d a=%h b=%h got %h_%h want %h_%h", i, o, a, b, rh, rl, exp[63:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_mthi_mtlo();
    test_multu_max();
    test_mult_small();
`ifdef MDU_DIV_EN
    test_div_cases();
`else
    test_no_div();
`endif
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
